// File: rtl/fp16_pkg.sv
// Shared fp16 constants and the accumulator state type for the dot-product accumulator.
package fp16_pkg;

  localparam int EXP_W    = 5;
  localparam int MAN_W    = 10;
  localparam int EXP_BIAS = 15;

  localparam logic [EXP_W-1:0] EXP_INF = EXP_W'(2 * EXP_BIAS + 1);

  localparam logic [15:0] FP16_QNAN = 16'h7e00;
  localparam logic [15:0] FP16_PINF = 16'h7c00;
  localparam logic [15:0] FP16_MAXF = 16'h7bff;

  typedef enum logic {
    ACC_EMPTY = 1'b0,
    ACC_ACCUM = 1'b1
  } acc_state_t;

endpackage

// File: rtl/fp16_adder.sv
// Combinational IEEE binary16 adder, round-to-nearest-even with subnormal support.
// Defining FP16_ACC_SAT_EN makes finite overflow saturate to +/-max finite instead of +/-inf.
module fp16_adder
  import fp16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  logic             a_nan, b_nan, a_inf, b_inf, swap, found, rnd;
  logic [15:0]      x, y, packed_r;
  logic [EXP_W-1:0] ex, ey, d;
  logic [MAN_W:0]   sig_x, sig_y;
  logic [47:0]      y_wide;
  logic [13:0]      x_al, y_al, n;
  logic [14:0]      r;
  logic [5:0]       e, e_n, exp_f;
  logic [3:0]       lz;

  always_comb begin
    a_nan = (a[14:10] == EXP_INF) && (a[MAN_W-1:0] != '0);
    b_nan = (b[14:10] == EXP_INF) && (b[MAN_W-1:0] != '0);
    a_inf = (a[14:10] == EXP_INF) && (a[MAN_W-1:0] == '0);
    b_inf = (b[14:10] == EXP_INF) && (b[MAN_W-1:0] == '0);

    // x always carries the larger magnitude so the subtraction below is non-negative
    swap  = b[14:0] > a[14:0];
    x     = swap ? b : a;
    y     = swap ? a : b;
    ex    = (x[14:10] == '0) ? EXP_W'(1) : x[14:10];
    ey    = (y[14:10] == '0) ? EXP_W'(1) : y[14:10];
    sig_x = {x[14:10] != '0, x[MAN_W-1:0]};
    sig_y = {y[14:10] != '0, y[MAN_W-1:0]};
    d     = ex - ey;

    // three guard bits (G, R, sticky); everything shifted past them folds into sticky
    y_wide = {sig_y, 37'd0} >> d;
    y_al   = {y_wide[47:35], y_wide[34] | (|y_wide[33:0])};
    x_al   = {sig_x, 3'b000};
    r      = (x[15] == y[15]) ? ({1'b0, x_al} + {1'b0, y_al})
                              : ({1'b0, x_al} - {1'b0, y_al});
    e      = {1'b0, ex};

    lz    = 4'd0;
    found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!found && r[i]) begin
        lz    = 4'(13 - i);
        found = 1'b1;
      end
    end

    if (r[14]) begin
      n   = {r[14:2], r[1] | r[0]};
      e_n = e + 6'd1;
    end else if (e > {2'b00, lz}) begin
      n   = r[13:0] << lz;
      e_n = e - {2'b00, lz};
    end else begin
      // result falls into the subnormal range: stop normalising at exponent 1
      n   = r[13:0] << (e - 6'd1);
      e_n = 6'd0;
    end

    exp_f    = n[13] ? e_n : 6'd0;
    rnd      = n[2] & (n[1] | n[0] | n[3]);
    packed_r = {exp_f, n[12:3]} + {15'd0, rnd};

    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
      sum = FP16_QNAN;
    end else if (a_inf) begin
      sum = a;
    end else if (b_inf) begin
      sum = b;
    end else if (r == '0) begin
      sum = {a[15] & b[15], 15'd0};
    end else if (packed_r > {1'b0, FP16_MAXF[14:0]}) begin
`ifdef FP16_ACC_SAT_EN
      sum = {x[15], FP16_MAXF[14:0]};
`else
      sum = {x[15], FP16_PINF[14:0]};
`endif
    end else begin
      sum = {x[15], packed_r[14:0]};
    end
  end

endmodule

// File: rtl/fp16_dot_accumulator.sv
// Accumulates groups of fp16 multiplier products into one sum per group and queues the sums.
// Overflow behaviour of the adder follows FP16_ACC_SAT_EN (see fp16_adder).
module fp16_dot_accumulator
  import fp16_pkg::*;
#(
  parameter int MUL_LAT   = 8,
  parameter int OUT_DEPTH = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic             op_last,
  input  logic [15:0]      prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             err_ovf
);

  localparam int AW = $clog2(OUT_DEPTH);

  logic [MUL_LAT-1:0] dv_q, dl_q;
  logic               p_valid, p_last, push, pop, full;
  acc_state_t         state;
  logic [15:0]        acc, add_sum, nxt_sum;
  logic [CNT_W-1:0]   cnt, nxt_cnt;
  logic [15:0]        fifo_sum [OUT_DEPTH];
  logic [CNT_W-1:0]   fifo_cnt [OUT_DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;

  fp16_adder u_adder (
    .a   (acc),
    .b   (prod),
    .sum (add_sum)
  );

  assign p_valid = dv_q[MUL_LAT-1];
  assign p_last  = dl_q[MUL_LAT-1];

  always_comb begin
    nxt_sum   = (state == ACC_EMPTY) ? prod : add_sum;
    nxt_cnt   = (state == ACC_EMPTY) ? CNT_W'(1) : ((&cnt) ? cnt : cnt + 1'b1);
    push      = p_valid & p_last;
    out_valid = (wr_ptr != rd_ptr);
    pop       = out_valid & out_ready;
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    out_sum   = fifo_sum[rd_ptr[AW-1:0]];
    out_count = fifo_cnt[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_q <= '0;
      dl_q <= '0;
    end else begin
      dv_q <= {dv_q[MUL_LAT-2:0], op_valid};
      dl_q <= {dl_q[MUL_LAT-2:0], op_valid & op_last};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACC_EMPTY;
      acc   <= '0;
      cnt   <= '0;
    end else if (p_valid) begin
      if (p_last) begin
        state <= ACC_EMPTY;
      end else begin
        state <= ACC_ACCUM;
        acc   <= nxt_sum;
        cnt   <= nxt_cnt;
      end
    end
  end

  // a pop in the same cycle frees the slot the full-FIFO push lands in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      err_ovf <= 1'b0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        fifo_sum[i] <= '0;
        fifo_cnt[i] <= '0;
      end
    end else begin
      if (push && (!full || pop)) begin
        fifo_sum[wr_ptr[AW-1:0]] <= nxt_sum;
        fifo_cnt[wr_ptr[AW-1:0]] <= nxt_cnt;
        wr_ptr                   <= wr_ptr + 1'b1;
      end else if (push) begin
        err_ovf <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp16_dot_accumulator.sv
// Scoreboard bench for fp16_dot_accumulator: a behavioural 8-cycle multiplier pipe feeds prod.
module tb_fp16_dot_accumulator;

  logic        clk = 1'b0;
  logic        rst, op_valid, op_last, out_ready, out_valid, err_ovf;
  logic [15:0] op_prod, prod, out_sum;
  logic [7:0]  out_count;
  logic [15:0] pipe [8];
  logic [23:0] sb_q [$];
  logic [23:0] sb_e;
  logic [15:0] ovf_exp;
  logic        seen;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe[0] <= op_prod;
    for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
  end
  assign prod = pipe[7];

  fp16_dot_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_last   (op_last),
    .prod      (prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .err_ovf   (err_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", sb_q.size(), 1);
      end else begin
        sb_e = sb_q.pop_front();
        chk("out_sum", {16'd0, out_sum}, {16'd0, sb_e[15:0]});
        chk("out_count", {24'd0, out_count}, {24'd0, sb_e[23:16]});
      end
    end
  end

  task automatic beat(input logic [15:0] p, input logic last, input logic [15:0] es,
                      input logic [7:0] ec, input logic keep);
    op_valid = 1'b1;
    op_last  = last;
    op_prod  = p;
    if (last && keep) sb_q.push_back({ec, es});
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(posedge clk);
    chk(tag, sb_q.size(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle"}, {31'd0, out_valid}, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_last = 1'b0; op_prod = 16'h0; out_ready = 1'b1;
`ifdef FP16_ACC_SAT_EN
    ovf_exp = 16'h7bff;
`else
    ovf_exp = 16'h7c00;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_sum", {16'd0, out_sum}, 0);
    chk("rst_count", {24'd0, out_count}, 0);
    chk("rst_ovf", {31'd0, err_ovf}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // latency: single-beat group must surface exactly one cycle after reaching the tap
    beat(16'h4400, 1'b1, 16'h4400, 8'd1, 1'b1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("lat_early", {31'd0, out_valid}, 0);
    @(negedge clk);
    chk("lat_on_time", {31'd0, out_valid}, 1);
    drain("lat_drain");

    beat(16'h3c00, 1'b0, 0, 0, 0);
    beat(16'h4000, 1'b0, 0, 0, 0);
    beat(16'h4200, 1'b1, 16'h4600, 8'd3, 1'b1);
    beat(16'h7c00, 1'b0, 0, 0, 0);
    beat(16'hfc00, 1'b1, 16'h7e00, 8'd2, 1'b1);
    beat(16'h7e00, 1'b1, 16'h7e00, 8'd1, 1'b1);
    drain("grp_basic");

    beat(16'h7bff, 1'b0, 0, 0, 0);
    beat(16'h7bff, 1'b1, ovf_exp, 8'd2, 1'b1);
    beat(16'hfbff, 1'b0, 0, 0, 0);
    beat(16'hfbff, 1'b1, {1'b1, ovf_exp[14:0]}, 8'd2, 1'b1);
    beat(16'h0001, 1'b0, 0, 0, 0);
    beat(16'h0001, 1'b1, 16'h0002, 8'd2, 1'b1);
    beat(16'h8000, 1'b1, 16'h8000, 8'd1, 1'b1);
    beat(16'h3c00, 1'b0, 0, 0, 0);
    beat(16'hbc00, 1'b1, 16'h0000, 8'd2, 1'b1);
    drain("grp_edge");

    // rounding ties to even, subnormal result, gap inside a group
    beat(16'h3c00, 1'b0, 0, 0, 0);
    beat(16'h1000, 1'b1, 16'h3c00, 8'd2, 1'b1);
    beat(16'h3c01, 1'b0, 0, 0, 0);
    beat(16'h1000, 1'b1, 16'h3c02, 8'd2, 1'b1);
    beat(16'h0400, 1'b0, 0, 0, 0);
    beat(16'h8001, 1'b1, 16'h03ff, 8'd2, 1'b1);
    beat(16'h3c00, 1'b0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    beat(16'h3c00, 1'b1, 16'h4000, 8'd2, 1'b1);
    drain("grp_round");

    for (int i = 0; i < 300; i++) beat(16'h0000, (i == 299), 16'h0000, 8'hff, 1'b1);
    drain("cnt_sat");

    out_ready = 1'b0;
    beat(16'h3c00, 1'b1, 16'h3c00, 8'd1, 1'b1);
    beat(16'h4000, 1'b1, 16'h4000, 8'd1, 1'b1);
    beat(16'h4200, 1'b1, 16'h4200, 8'd1, 1'b0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("full_valid", {31'd0, out_valid}, 1);
    chk("full_ovf", {31'd0, err_ovf}, 1);
    chk("full_head", {16'd0, out_sum}, 32'h3c00);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("fifo_drain");

    // reset with two beats accumulated and three still in the delay line
    for (int i = 0; i < 5; i++) beat(16'h3c00, (i == 4), 0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_ovf", {31'd0, err_ovf}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_stale_out", {31'd0, seen}, 0);
    @(posedge clk);
    #1;
    beat(16'h3c00, 1'b1, 16'h3c00, 8'd1, 1'b1);
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
